interboard_tx: RTL and testbench
================================

Name: interboard_tx

Overview:
- Transmit half of the two-board link.
- Sits between GameControl (ctrl_* message fields, transmit strobe) and the board pins Request_out / inter_data_out / Ack_in.
- Packs one game message into four 6-bit words and sends them to the peer board with a 4-phase Request/Ack handshake.
- Reports ready, done and timeout status back to the control logic.

Parameters:
- SETUP_CYCLES, 2: cycles data must be stable on inter_data_out before Request_out rises (≥1).
- TIMEOUT, 1000000: max cycles spent waiting for any single Ack edge before aborting (10 ms at 100 MHz).
- SYNC_STAGES, 2: flip-flop stages on Ack_in (≥2).

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  reset: asynchronous, active-low (decided)
- tx_en  in  1  one-cycle request to send a message; sampled only in IDLE
- tx_msg_type  in  4  message type
- tx_block_x  in  5  map column
- tx_block_y  in  3  map row
- tx_card  in  6  card id
- tx_sel_len  in  3  selected-run length
- tx_move_dir  in  1  move direction
- Ack_in  in  1  peer acknowledge (asynchronous to clk)
- tx_ready  out  1  high in IDLE only
- tx_done  out  1  one-cycle pulse after the 4th word completes
- tx_err  out  1  one-cycle pulse on timeout abort
- Request_out  out  1  handshake request to peer (registered)
- inter_data_out  out  6  word on the wire (registered)

Behaviour:
- Reset (rst=0, async): state=IDLE, Request_out=0, inter_data_out=0, tx_ready=1, tx_done=0, tx_err=0, word index=0, counters=0, sync chain=0.
- Frame packing, 24 bits: F = {2'b00, move_dir, sel_len, card, block_y, block_x, msg_type}, msg_type in F[3:0]. Fields are latched on the accepted tx_en.
- Word k (k=0..3) = F[6k+5:6k], sent LSW first.
- Ack_in passes through SYNC_STAGES flops before use. ack_s is the last stage.
- FSM states:
  - IDLE: on tx_en, latch F, drive word0, clear counters, go SETUP. Next cycle tx_ready=0.
  - SETUP: count to SETUP_CYCLES, then Request_out←1 and go WAIT_HI.
  - WAIT_HI: wait for ack_s=1, then Request_out←0 and go WAIT_LO.
  - WAIT_LO: wait for ack_s=0.
    - If word index<3: increment index, drive the next word, go SETUP.
    - If index=3: pulse tx_done, Request_out=0, inter_data_out←0, go IDLE.
- Latency:
  - tx_en at cycle t gives word0 on the wire at t+1 and Request_out=1 at t+1+SETUP_CYCLES.
  - Each word costs SETUP_CYCLES + 2·(peer response + SYNC_STAGES) cycles minimum.
- Timeout:
  - The wait counter resets on every entry to WAIT_HI or WAIT_LO.
  - If it reaches TIMEOUT: pulse tx_err, Request_out←0, inter_data_out←0, go IDLE. tx_done is not pulsed.
- Data is held stable from SETUP entry through the end of WAIT_LO. It never changes while Request_out=1.
- tx_en outside IDLE is ignored: no queueing, fields not re-latched.
- tx_en and the IDLE return in the same cycle: the new tx_en is not accepted. tx_ready=1 is required first.
- Ack_in already high when entering WAIT_HI for the first time (stale peer) is accepted as the ack. The protocol is level-based; the peer is responsible for correct levels.
- Reset mid-frame: immediate abort, outputs return to reset values. No tx_done or tx_err pulse.
- Counter widths: $clog2(TIMEOUT+1) and $clog2(SETUP_CYCLES+1). No wrap is possible because the FSM exits at the terminal value.

Decomposition:
- Shared interboard package holds:
  - WORD_W=6, WORDS_PER_MSG=4, FRAME_W=24
  - frame field offsets (MSG_LSB=0, BX_LSB=4, BY_LSB=9, CARD_LSB=12, LEN_LSB=18, DIR_LSB=21)
  - FSM state typedef
- The receive side uses the same package for unpacking.
- One sub-module: sync_ff (parameterised SYNC_STAGES synchronizer with async active-low reset), reused on the RX side for Request_in.

Test Plan:
- Packing, SETUP_CYCLES=2, auto-ack peer with 3-cycle delay: tx_en with msg_type=3, block_x=17, block_y=5, card=42, sel_len=2, move_dir=1 → inter_data_out sequence 6'h13, 6'h2C, 6'h2A, 6'h0A, each stable while Request_out=1; single tx_done; tx_ready returns to 1.
- Setup timing: tx_en at cycle 10 → inter_data_out=6'h13 at cycle 11, Request_out rises at cycle 13, never earlier.
- Timeout, TIMEOUT=50: peer never acks → tx_err pulses exactly once, 50 cycles after WAIT_HI entry; Request_out=0; no tx_done; tx_ready=1.
- Busy rejection: second tx_en with card=7 during word1 → transmitted words unchanged from the first message; exactly one tx_done.
- Reset mid-frame: assert rst=0 during WAIT_HI of word2 → Request_out=0 and inter_data_out=0 asynchronously (before next clk edge); after release, a new message sends cleanly from word0.
- Ack stuck high after WAIT_LO (peer never drops) with TIMEOUT=50 → tx_err after 50 cycles; next message succeeds once the peer is repaired.

Source files
------------

// File: rtl/interboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : interboard_pkg
// Description : Shared definitions for the two-board link (TX and RX sides):
//               word/frame geometry, frame field offsets, TX FSM states and
//               frame pack / word-extract helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package interboard_pkg;

  localparam int WORD_W        = 6;
  localparam int WORDS_PER_MSG = 4;
  localparam int FRAME_W       = 24;

  // Frame field offsets; bits [23:22] are always zero
  localparam int MSG_LSB  = 0;
  localparam int BX_LSB   = 4;
  localparam int BY_LSB   = 9;
  localparam int CARD_LSB = 12;
  localparam int LEN_LSB  = 18;
  localparam int DIR_LSB  = 21;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_WAIT_HI = 2'd2,
    ST_WAIT_LO = 2'd3
  } tx_state_e;

  // Assemble the 24-bit frame from the individual game-message fields
  function automatic logic [FRAME_W-1:0] pack_frame(
    input logic [3:0] msg_type,
    input logic [4:0] block_x,
    input logic [2:0] block_y,
    input logic [5:0] card,
    input logic [2:0] sel_len,
    input logic       move_dir
  );
    logic [FRAME_W-1:0] f;
    f                 = '0;
    f[MSG_LSB  +: 4]  = msg_type;
    f[BX_LSB   +: 5]  = block_x;
    f[BY_LSB   +: 3]  = block_y;
    f[CARD_LSB +: 6]  = card;
    f[LEN_LSB  +: 3]  = sel_len;
    f[DIR_LSB]        = move_dir;
    return f;
  endfunction

  // Word k of a frame; word 0 is the least significant and goes out first
  function automatic logic [WORD_W-1:0] frame_word(
    input logic [FRAME_W-1:0] f,
    input logic [1:0]         k
  );
    return f[int'(k)*WORD_W +: WORD_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/interboard_if.sv
`default_nettype none
// ============================================================================
// Module      : interboard_if
// Description : Bundle of control-side message fields/status and board-pin
//               handshake signals for the transmit half of the link.
//               master = control logic + peer board, slave = transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface interboard_if;

  // Control side
  logic       tx_en;
  logic [3:0] tx_msg_type;
  logic [4:0] tx_block_x;
  logic [2:0] tx_block_y;
  logic [5:0] tx_card;
  logic [2:0] tx_sel_len;
  logic       tx_move_dir;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_err;

  // Board pins
  logic       Ack_in;
  logic       Request_out;
  logic [5:0] inter_data_out;

  modport master (
    output tx_en, tx_msg_type, tx_block_x, tx_block_y, tx_card, tx_sel_len,
           tx_move_dir, Ack_in,
    input  tx_ready, tx_done, tx_err, Request_out, inter_data_out
  );

  modport slave (
    input  tx_en, tx_msg_type, tx_block_x, tx_block_y, tx_card, tx_sel_len,
           tx_move_dir, Ack_in,
    output tx_ready, tx_done, tx_err, Request_out, inter_data_out
  );

endinterface
`default_nettype wire

// File: rtl/interboard_tx_sync_ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_ff
// Description : STAGES-deep flip-flop synchronizer for a single asynchronous
//               level (Ack_in on TX, Request_in on RX). Reset is asynchronous
//               and active-low.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,   // active-low
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous level through the chain, oldest sample at the top
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/interboard_tx.sv
`default_nettype none
// ============================================================================
// Module      : interboard_tx
// Description : Transmit half of the two-board link. Packs one game message
//               into four 6-bit words and sends them LSW first using a
//               4-phase Request/Ack handshake, with per-edge timeout.
//               rst is asynchronous and active-low.
// Revision    : 1.0 - initial release
// ============================================================================
module interboard_tx
  import interboard_pkg::*;
#(
  parameter int SETUP_CYCLES = 2,
  parameter int TIMEOUT      = 1000000,
  parameter int SYNC_STAGES  = 2
) (
  input  logic         clk,
  input  logic         rst,   // active-low
  interboard_if.slave  bus
);

  localparam int SETUP_W = $clog2(SETUP_CYCLES + 1);
  localparam int WAIT_W  = $clog2(TIMEOUT + 1);
  localparam logic [SETUP_W-1:0] SETUP_LAST = SETUP_W'(SETUP_CYCLES - 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(TIMEOUT - 1);
  localparam logic [1:0]         LAST_IDX   = 2'(WORDS_PER_MSG - 1);

  tx_state_e           state_q;
  logic [FRAME_W-1:0]  frame_q;
  logic [FRAME_W-1:0]  frame_d;
  logic [1:0]          idx_q;
  logic [SETUP_W-1:0]  setup_cnt_q;
  logic [WAIT_W-1:0]   wait_cnt_q;
  logic                req_q;
  logic [WORD_W-1:0]   data_q;
  logic                ready_q;
  logic                done_q;
  logic                err_q;
  logic                ack_s;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.Ack_in),
    .q_o (ack_s)
  );

  // Frame candidate from the current control fields; latched only on accept
  assign frame_d = pack_frame(bus.tx_msg_type, bus.tx_block_x, bus.tx_block_y,
                              bus.tx_card, bus.tx_sel_len, bus.tx_move_dir);

  // Handshake sequencer: word setup, wait for Ack high, wait for Ack low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      frame_q     <= '0;
      idx_q       <= '0;
      setup_cnt_q <= '0;
      wait_cnt_q  <= '0;
      req_q       <= 1'b0;
      data_q      <= '0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.tx_en) begin
            frame_q     <= frame_d;
            data_q      <= frame_word(frame_d, 2'd0);
            idx_q       <= '0;
            setup_cnt_q <= '0;
            wait_cnt_q  <= '0;
            ready_q     <= 1'b0;
            state_q     <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (setup_cnt_q == SETUP_LAST) begin
            req_q      <= 1'b1;
            wait_cnt_q <= '0;
            state_q    <= ST_WAIT_HI;
          end else begin
            setup_cnt_q <= setup_cnt_q + 1'b1;
          end
        end

        ST_WAIT_HI: begin
          if (ack_s) begin
            req_q      <= 1'b0;
            wait_cnt_q <= '0;
            state_q    <= ST_WAIT_LO;
          end else if (wait_cnt_q == WAIT_LAST) begin
            err_q   <= 1'b1;
            req_q   <= 1'b0;
            data_q  <= '0;
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end

        ST_WAIT_LO: begin
          if (!ack_s) begin
            if (idx_q != LAST_IDX) begin
              idx_q       <= idx_q + 1'b1;
              data_q      <= frame_word(frame_q, idx_q + 1'b1);
              setup_cnt_q <= '0;
              state_q     <= ST_SETUP;
            end else begin
              done_q  <= 1'b1;
              req_q   <= 1'b0;
              data_q  <= '0;
              ready_q <= 1'b1;
              state_q <= ST_IDLE;
            end
          end else if (wait_cnt_q == WAIT_LAST) begin
            err_q   <= 1'b1;
            req_q   <= 1'b0;
            data_q  <= '0;
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.Request_out    = req_q;
  assign bus.inter_data_out = data_q;
  assign bus.tx_ready       = ready_q;
  assign bus.tx_done        = done_q;
  assign bus.tx_err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_interboard_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_interboard_tx
// Description : Directed self-checking bench for interboard_tx with a peer
//               model (auto-ack after 3 cycles, silent, or stuck-high Ack).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interboard_tx;

  localparam int SETUP = 2;
  localparam int TO    = 50;
  localparam int SYNC  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  interboard_if bus();

  interboard_tx #(
    .SETUP_CYCLES (SETUP),
    .TIMEOUT      (TO),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Peer model: 0 = auto-ack after 3 cycles, 1 = never acks, 2 = Ack sticks high
  int         peer_mode = 0;
  logic [2:0] req_dly   = '0;
  logic       stuck     = 1'b0;
  always @(posedge clk) begin
    req_dly <= {req_dly[1:0], bus.Request_out};
    stuck   <= (peer_mode == 2) && (stuck || req_dly[2]);
  end
  assign bus.Ack_in = (peer_mode == 1) ? 1'b0 :
                      (peer_mode == 2) ? (req_dly[2] | stuck) : req_dly[2];

  // Wire monitor: words captured on each Request rise, pulse counts, stability
  logic [5:0] wbuf [64];
  int   wcnt = 0, done_cnt = 0, err_cnt = 0, stab_err = 0;
  int   cyc = 0, rise_cyc = 0, err_cyc = 0;
  logic prev_req = 1'b0;
  logic [5:0] prev_data = '0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.Request_out === 1'b1 && prev_req !== 1'b1) begin
      if (wcnt < 64) wbuf[wcnt] = bus.inter_data_out;
      wcnt++;
      rise_cyc = cyc;
    end
    if (bus.Request_out === 1'b1 && prev_req === 1'b1 && bus.inter_data_out !== prev_data)
      stab_err++;
    if (bus.tx_done === 1'b1) done_cnt++;
    if (bus.tx_err === 1'b1) begin
      err_cnt++;
      err_cyc = cyc;
    end
    prev_req  = bus.Request_out;
    prev_data = bus.inter_data_out;
  end

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [3:0] m, input logic [4:0] bx, input logic [2:0] by,
                       input logic [5:0] cd, input logic [2:0] ln, input logic dr);
    @(posedge clk); #1;
    bus.tx_msg_type = m;  bus.tx_block_x = bx; bus.tx_block_y = by;
    bus.tx_card     = cd; bus.tx_sel_len = ln; bus.tx_move_dir = dr;
    bus.tx_en       = 1'b1;
    @(posedge clk); #1;
    bus.tx_en       = 1'b0;
  endtask

  task automatic wait_done(input int target, input string tag);
    int n = 0;
    while (done_cnt < target && n < 400) begin @(posedge clk); n++; end
    @(negedge clk);
    check(tag, done_cnt, target);
  endtask

  task automatic wait_err(input int target, input string tag);
    int n = 0;
    while (err_cnt < target && n < 400) begin @(posedge clk); n++; end
    @(negedge clk);
    check(tag, err_cnt, target);
  endtask

  task automatic check_words(input int base, input logic [5:0] w0, input logic [5:0] w1,
                             input logic [5:0] w2, input logic [5:0] w3, input string tag);
    logic [5:0] exp [4];
    exp[0] = w0; exp[1] = w1; exp[2] = w2; exp[3] = w3;
    check({tag, "_count"}, wcnt - base, 4);
    for (int k = 0; k < 4; k++)
      check($sformatf("%s_w%0d", tag, k), wbuf[base + k], exp[k]);
  endtask

  initial begin
    int base, d0, e0, n;
    bus.tx_en = 1'b0; bus.tx_msg_type = '0; bus.tx_block_x = '0; bus.tx_block_y = '0;
    bus.tx_card = '0; bus.tx_sel_len = '0; bus.tx_move_dir = 1'b0;
    rst = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_req",   bus.Request_out,    0);
    check("rst_data",  bus.inter_data_out, 0);
    check("rst_ready", bus.tx_ready,       1);
    check("rst_done",  bus.tx_done,        0);
    check("rst_err",   bus.tx_err,         0);
    rst = 1'b1;
    repeat (3) @(posedge clk);

    // Packing and setup timing: words 13,2C,2A,0A
    base = wcnt; d0 = done_cnt;
    start(4'd3, 5'd17, 3'd5, 6'd42, 3'd2, 1'b1);
    check("setup_data_t1",  bus.inter_data_out, 6'h13);
    check("setup_req_t1",   bus.Request_out,    0);
    check("setup_ready_t1", bus.tx_ready,       0);
    @(posedge clk); #1;
    check("setup_req_t2",   bus.Request_out,    0);
    @(posedge clk); #1;
    check("setup_req_t3",   bus.Request_out,    1);
    check("setup_data_t3",  bus.inter_data_out, 6'h13);
    wait_done(d0 + 1, "pack_done");
    check("pack_ready", bus.tx_ready,       1);
    check("pack_idle_data", bus.inter_data_out, 0);
    check_words(base, 6'h13, 6'h2C, 6'h2A, 6'h0A, "pack");
    repeat (5) @(posedge clk);
    check("pack_single_done", done_cnt, d0 + 1);

    // Timeout in WAIT_HI: peer silent
    peer_mode = 1; e0 = err_cnt; d0 = done_cnt;
    start(4'd3, 5'd17, 3'd5, 6'd42, 3'd2, 1'b1);
    wait_err(e0 + 1, "to_err");
    check("to_latency", err_cyc - rise_cyc, TO);
    check("to_req",     bus.Request_out,    0);
    check("to_data",    bus.inter_data_out, 0);
    check("to_ready",   bus.tx_ready,       1);
    check("to_no_done", done_cnt,           d0);
    repeat (60) @(posedge clk);
    check("to_err_once", err_cnt, e0 + 1);
    peer_mode = 0;
    repeat (5) @(posedge clk);

    // Busy rejection: second tx_en (card=7) during word1 is ignored
    base = wcnt; d0 = done_cnt;
    start(4'd3, 5'd17, 3'd5, 6'd42, 3'd2, 1'b1);
    n = 0;
    while (wcnt < base + 2 && n < 200) begin @(posedge clk); n++; end
    check("busy_word1_seen", 32'(wcnt >= base + 2), 1);
    bus.tx_card = 6'd7; bus.tx_en = 1'b1;
    @(posedge clk); #1;
    bus.tx_en = 1'b0;
    wait_done(d0 + 1, "busy_done");
    check_words(base, 6'h13, 6'h2C, 6'h2A, 6'h0A, "busy");
    repeat (20) @(posedge clk);
    check("busy_single_done", done_cnt, d0 + 1);
    check("busy_no_restart",  wcnt - base, 4);

    // Reset during WAIT_HI of word2
    base = wcnt; d0 = done_cnt; e0 = err_cnt;
    start(4'd3, 5'd17, 3'd5, 6'd42, 3'd2, 1'b1);
    n = 0;
    while (wcnt < base + 3 && n < 200) begin @(posedge clk); n++; end
    check("rstmid_word2_seen", 32'(wcnt >= base + 3), 1);
    #2 rst = 1'b0;
    #1;
    check("rstmid_req_async",  bus.Request_out,    0);
    check("rstmid_data_async", bus.inter_data_out, 0);
    check("rstmid_ready",      bus.tx_ready,       1);
    @(posedge clk); #1 rst = 1'b1;
    repeat (10) @(posedge clk);
    check("rstmid_no_done", done_cnt, d0);
    check("rstmid_no_err",  err_cnt,  e0);
    base = wcnt;
    start(4'hF, 5'd0, 3'd7, 6'h3F, 3'd7, 1'b0);
    wait_done(d0 + 1, "rstmid_next_done");
    check_words(base, 6'h0F, 6'h38, 6'h3F, 6'h07, "rstmid_next");

    // Ack stuck high in WAIT_LO, then peer repaired
    peer_mode = 2; e0 = err_cnt; d0 = done_cnt;
    start(4'd3, 5'd17, 3'd5, 6'd42, 3'd2, 1'b1);
    wait_err(e0 + 1, "stuck_err");
    check("stuck_no_done", done_cnt,        d0);
    check("stuck_req",     bus.Request_out, 0);
    peer_mode = 0;
    repeat (10) @(posedge clk);
    base = wcnt;
    start(4'd3, 5'd17, 3'd5, 6'd42, 3'd2, 1'b1);
    wait_done(d0 + 1, "repair_done");
    check_words(base, 6'h13, 6'h2C, 6'h2A, 6'h0A, "repair");

    check("data_stable_under_req", stab_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
